small_buffer_arbiter: RTL and testbench
=======================================

# small_buffer_arbiter

Round-robin batch arbiter that shares one `small_buffer_ctrl` instance between `N_REQ` upstream 256-bit streams. It grants the buffer's input port to one requester for exactly one full buffer load (`BATCH_LEN` beats), so batches never interleave. It drives the multiply-tree `mode` for that batch and tags every result beat with the requester that owns it. It sits between the requester streams and the buffer's `interface_in` / `interface_out` ports.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; ≥2.
- `TW`, 2 — tag width, `clog2(N_REQ)`.
- `BATCH_LEN`, 16 — beats per batch; must equal the buffer depth.
- `OUT_PER_BATCH`, 16 — `output_vld` beats per batch produced by the buffer.
- `TAG_DEPTH`, 4 — in-flight batch tag FIFO depth; power of 2.

Ports:
- `clk`  in  1  clock; reset `rst` is synchronous, active-high; clock `clk`.
- `rst`  in  1  synchronous active-high reset.
- `req_data`  in  N_REQ*256  requester i occupies bits [i*256 +: 256].
- `req_vld`  in  N_REQ  per-requester valid.
- `req_ready`  out  N_REQ  per-requester ready.
- `req_mode`  in  N_REQ*2  per-requester mode; sampled at grant.
- `buf_data`  out  256  to buffer `interface_in`.
- `buf_vld`  out  1  to buffer `input_vld`.
- `buf_ready`  in  1  from buffer `input_ready`.
- `buf_mode`  out  2  to buffer `mode`.
- `buf_out_vld`  in  1  from buffer `output_vld`.
- `res_tag`  out  TW  owner of the current result beat; valid while `buf_out_vld`.
- `res_last`  out  1  current result beat is the batch's last.
- `err_orphan`  out  1  sticky: a result beat arrived with the tag FIFO empty.
- `busy`  out  1  state≠IDLE or tag FIFO non-empty.

## Operation
- States: IDLE, STREAM, MODE_WAIT.
- **IDLE:** the candidate is the first `req_vld` bit scanning from `rr_ptr` upward, with wraparound.
  - Grant requires a candidate, tag FIFO not full, and `buf_ready`=1.
  - On grant: latch `grant`, set `buf_mode` to the candidate's mode, push `grant` into the tag FIFO, clear `beat_cnt`, go to STREAM.
- **Mode check:** if the candidate's mode ≠ `buf_mode` and the tag FIFO is non-empty, go to MODE_WAIT instead of granting.
- **MODE_WAIT:** stay until the tag FIFO is empty, then return to IDLE; arbitration re-runs there, so the candidate may change.
- **STREAM:** `buf_data`=`req_data[grant]`, `buf_vld`=`req_vld[grant]`, `req_ready[grant]`=`buf_ready`; all other `req_ready` are 0.
  - `beat_cnt` increments on `buf_vld & buf_ready`.
  - The handshake with `beat_cnt`=`BATCH_LEN-1` returns the block to IDLE and sets `rr_ptr`=`(grant+1) mod N_REQ`.
- **Outside STREAM:** `buf_vld`=0 and all `req_ready`=0.
- **Result side:** `out_cnt` counts `buf_out_vld` beats. `res_tag` is the FIFO head; `res_last`=`buf_out_vld & (out_cnt==OUT_PER_BATCH-1)`. On `res_last`, pop the FIFO and clear `out_cnt`.
- **Simultaneous push and pop:** both take effect; occupancy is unchanged.
- **Orphan beat:** `buf_out_vld` with the FIFO empty sets `err_orphan`. Nothing is popped and `out_cnt` does not change.
- **Requester drops `req_vld` mid-batch:** the block stalls in STREAM with no timeout; the grant is held.
- **`rr_ptr` on an N_REQ that is not a power of 2:** the pointer wraps explicitly at `N_REQ-1`.

## Timing
- **Reset values:** state=IDLE, `rr_ptr`=0, `grant`=0, `buf_mode`=0, `beat_cnt`=0, `out_cnt`=0, FIFO empty, `err_orphan`=0, `busy`=0, `buf_vld`=0, `req_ready`=0, `res_last`=0.
- **Reset mid-batch:** abandons the batch and clears all state. Reset the buffer together with this block.
- **Grant latency:** a grant decided in cycle t makes STREAM active in t+1. The first possible data beat is t+1.
- **Stream path:** combinational `req_*` → `buf_*` in STREAM, with no added latency.
- **Result path:** `res_tag` and `res_last` are combinational from the FIFO head and `out_cnt`.
- **Back-to-back batches:** the minimum gap is one idle cycle (the IDLE decision cycle) plus any `buf_ready`-low time.
- **`buf_mode`:** changes only at a grant. It never changes while the FIFO holds a batch of a different mode.

## Test plan
- **Single requester:** rst; req0 streams 16 beats with mode=1 → exactly 16 handshakes; `buf_mode`=1 from the grant cycle; 16 result beats with `res_tag`=0 and `res_last` on the 16th; `busy` returns to 0.
- **Round robin:** all 4 requesters hold `req_vld`=1 with equal modes → grant order 0,1,2,3,0; no interleaving within a batch; `rr_ptr` wraps 3→0.
- **Mode change:** req0 mode 0, req1 mode 2 → after req0's batch, the block enters MODE_WAIT until req0's 16th result beat pops; then req1 is granted and `buf_mode`=2.
- **Tag FIFO full:** 4 batches loaded with results withheld → no fifth grant; the first `res_last` pop allows a grant on the next IDLE cycle. Include a same-cycle push and pop.
- **Stall and reset:** req2 drops `req_vld` after beat 7 → stays in STREAM with `beat_cnt`=7; assert rst → all outputs at reset values next cycle.
- **Orphan:** `buf_out_vld` pulse with the FIFO empty → `err_orphan`=1 and stays 1 until rst.

Source files
------------

// File: rtl/small_buffer_arbiter_if.sv
// Requester-side and buffer-side signal bundle for small_buffer_arbiter.
// The master modport is the arbiter's view; slave is the surrounding requester/buffer side.
interface small_buffer_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int TW    = 2
);
  logic [N_REQ*256-1:0] req_data;
  logic [N_REQ-1:0]     req_vld;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*2-1:0]   req_mode;
  logic [255:0]         buf_data;
  logic                 buf_vld;
  logic                 buf_ready;
  logic [1:0]           buf_mode;
  logic                 buf_out_vld;
  logic [TW-1:0]        res_tag;
  logic                 res_last;
  logic                 err_orphan;
  logic                 busy;

  modport master (
    input  req_data, req_vld, req_mode, buf_ready, buf_out_vld,
    output req_ready, buf_data, buf_vld, buf_mode, res_tag, res_last, err_orphan, busy
  );

  modport slave (
    output req_data, req_vld, req_mode, buf_ready, buf_out_vld,
    input  req_ready, buf_data, buf_vld, buf_mode, res_tag, res_last, err_orphan, busy
  );
endinterface

// File: rtl/small_buffer_arbiter.sv
// Round-robin batch arbiter: hands the shared buffer input to one requester for a
// whole BATCH_LEN-beat load and tags each result beat with the batch owner.
//
// state     | meaning
// IDLE      | pick next requester from rr_ptr, grant when buffer and tag FIFO allow
// STREAM    | granted requester streams straight through to the buffer
// MODE_WAIT | candidate needs another mode; wait for in-flight batches to drain
module small_buffer_arbiter #(
  parameter int N_REQ         = 4,
  parameter int TW            = 2,
  parameter int BATCH_LEN     = 16,
  parameter int OUT_PER_BATCH = 16,
  parameter int TAG_DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst,
  small_buffer_arbiter_if.master bus
);

  localparam int BW = (BATCH_LEN > 1) ? $clog2(BATCH_LEN) : 1;
  localparam int OW = (OUT_PER_BATCH > 1) ? $clog2(OUT_PER_BATCH) : 1;
  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, MODE_WAIT} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   rr_ptr;
  logic [TW-1:0]   grant;
  logic [1:0]      mode_q;
  logic [BW-1:0]   beat_cnt;
  logic [OW-1:0]   out_cnt;
  logic            err_q;

  logic [TW-1:0]   tags [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   tag_cnt;
  logic            fifo_empty, fifo_full;

  logic            cand_found;
  logic [TW-1:0]   cand;
  logic [TW-1:0]   scan_idx;
  int              scan_sum;
  logic [1:0]      cand_mode;

  logic            grant_now, stream_done, hs, pop;

  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = (tag_cnt == CW'(TAG_DEPTH));

  // First valid requester at or after rr_ptr; wraps explicitly so odd N_REQ works.
  always_comb begin
    cand_found = 1'b0;
    cand       = '0;
    scan_idx   = '0;
    scan_sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = int'(rr_ptr) + k;
      if (scan_sum >= N_REQ) scan_sum = scan_sum - N_REQ;
      scan_idx = TW'(scan_sum);
      if (!cand_found && bus.req_vld[scan_idx]) begin
        cand_found = 1'b1;
        cand       = scan_idx;
      end
    end
  end

  assign cand_mode = bus.req_mode[{cand, 1'b0} +: 2];

  always_comb begin
    bus.buf_data  = bus.req_data[int'(grant)*256 +: 256];
    bus.buf_vld   = 1'b0;
    bus.req_ready = '0;
    if (state == STREAM) begin
      bus.buf_vld          = bus.req_vld[grant];
      bus.req_ready[grant] = bus.buf_ready;
    end
  end

  assign hs = bus.buf_vld & bus.buf_ready;

  always_comb begin
    state_nxt   = state;
    grant_now   = 1'b0;
    stream_done = 1'b0;
    case (state)
      IDLE: begin
        if (cand_found) begin
          if ((cand_mode != mode_q) && !fifo_empty) begin
            state_nxt = MODE_WAIT;
          end else if (!fifo_full && bus.buf_ready) begin
            grant_now = 1'b1;
            state_nxt = STREAM;
          end
        end
      end
      MODE_WAIT: begin
        if (fifo_empty) state_nxt = IDLE;
      end
      STREAM: begin
        if (hs && (beat_cnt == BW'(BATCH_LEN - 1))) begin
          stream_done = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.res_last = bus.buf_out_vld & !fifo_empty & (out_cnt == OW'(OUT_PER_BATCH - 1));
  assign pop          = bus.res_last;
  assign bus.res_tag  = tags[rd_ptr];
  assign bus.buf_mode = mode_q;
  assign bus.err_orphan = err_q;
  assign bus.busy     = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      mode_q   <= '0;
      beat_cnt <= '0;
      out_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (grant_now) begin
        grant    <= cand;
        mode_q   <= cand_mode;
        beat_cnt <= '0;
        wr_ptr   <= wr_ptr + 1'b1;
      end else if (stream_done) begin
        beat_cnt <= '0;
      end else if (hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (stream_done) rr_ptr <= (grant == TW'(N_REQ - 1)) ? '0 : grant + 1'b1;

      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_cnt <= '0;
      end else if (bus.buf_out_vld && !fifo_empty) begin
        out_cnt <= out_cnt + 1'b1;
      end

      case ({grant_now, pop})
        2'b10:   tag_cnt <= tag_cnt + 1'b1;
        2'b01:   tag_cnt <= tag_cnt - 1'b1;
        default: tag_cnt <= tag_cnt;
      endcase

      if (bus.buf_out_vld && fifo_empty) err_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; occupancy is tracked by tag_cnt.
  always_ff @(posedge clk) begin
    if (grant_now) tags[wr_ptr] <= cand;
  end

endmodule

// File: tb/tb_small_buffer_arbiter.sv
// Scoreboard bench for small_buffer_arbiter: planned grants are queued by the stimulus,
// checked beat by beat on the buffer side, then tracked as tags on the result side.
module tb_small_buffer_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst;

  small_buffer_arbiter_if #(.N_REQ(N), .TW(2)) bus ();

  small_buffer_arbiter #(
    .N_REQ(N), .TW(2), .BATCH_LEN(16), .OUT_PER_BATCH(16), .TAG_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // requester model: target written by stimulus, sent written by driver
  int target [N];
  int sent   [N];
  int rx     [N];

  int exp_gid[$];
  int exp_gmode[$];
  int exp_tag[$];

  int res_mode   = 0;
  logic manual_vld = 1'b0;

  int cyc = 0, exp_idx = 0, beat = 0, res_cnt = 0;
  int batches = 0, hs_total = 0, res_total = 0, last_mode = 0;
  int first_pop_cyc = -1, batch_start_cyc = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    res_mode   = 0;
    manual_vld = 1'b0;
    bus.buf_ready = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic plan(input int id, input int mode);
    exp_gid.push_back(id);
    exp_gmode.push_back(mode);
  endtask

  task automatic wait_batches(input int k, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (batches >= k) break;
      step(1);
    end
    chk("batches_reached", 256'(batches), 256'(k));
  endtask

  task automatic wait_beats(input int k, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (hs_total >= k) break;
      step(1);
    end
    chk("beats_reached", 256'(hs_total), 256'(k));
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!bus.busy) break;
      step(1);
    end
    chk("busy_clear", 256'(bus.busy), 256'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_buf_vld"},    256'(bus.buf_vld),    256'(0));
    chk({tag, "_req_ready"},  256'(bus.req_ready),  256'(0));
    chk({tag, "_res_last"},   256'(bus.res_last),   256'(0));
    chk({tag, "_err_orphan"}, 256'(bus.err_orphan), 256'(0));
    chk({tag, "_busy"},       256'(bus.busy),       256'(0));
    chk({tag, "_buf_mode"},   256'(bus.buf_mode),   256'(0));
  endtask

  // Requester driver: valid while beats remain, data = {id, beat sequence}.
  initial begin
    logic [N-1:0] hs_s;
    bus.req_vld  = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) sent[i] = 0;
    forever begin
      @(negedge clk);
      hs_s = bus.req_vld & bus.req_ready;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (rst) sent[i] = target[i];
        else if (hs_s[i]) sent[i]++;
        bus.req_vld[i] = (sent[i] < target[i]);
        bus.req_data[i*256 +: 256] = {8'(i), 248'(sent[i])};
      end
    end
  end

  // Result-side driver: auto mode emits beats while results are owed.
  initial begin
    bus.buf_out_vld = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (res_mode == 1)      bus.buf_out_vld = (exp_tag.size() != 0);
      else if (res_mode == 2) bus.buf_out_vld = manual_vld;
      else                    bus.buf_out_vld = 1'b0;
    end
  end

  // Monitor / scoreboard
  initial begin
    int g, m;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_tag.delete();
        beat = 0; res_cnt = 0; batches = 0; hs_total = 0; res_total = 0;
        last_mode = 0; first_pop_cyc = -1;
        exp_idx = exp_gid.size();
        for (int i = 0; i < N; i++) rx[i] = sent[i];
      end else begin
        if (bus.buf_vld && bus.buf_ready) begin
          hs_total++;
          if (exp_idx < exp_gid.size()) begin
            g = exp_gid[exp_idx];
            m = exp_gmode[exp_idx];
            if (beat == 0) begin
              batch_start_cyc = cyc;
              chk("buf_mode_at_grant", 256'(bus.buf_mode), 256'(m));
              if (m != last_mode) chk("mode_wait_drained", 256'(exp_tag.size()), 256'(0));
            end
            chk("req_ready_owner", 256'(bus.req_ready), 256'(1 << g));
            chk("buf_data", bus.buf_data, {8'(g), 248'(rx[g])});
            rx[g]++;
            beat++;
            if (beat == 16) begin
              beat = 0;
              exp_tag.push_back(g);
              exp_idx++;
              batches++;
              last_mode = m;
            end
          end else begin
            chk("unplanned_beat", 256'(bus.buf_vld), 256'(0));
          end
        end
        if (bus.buf_out_vld && exp_tag.size() != 0) begin
          res_total++;
          chk("res_tag", 256'(bus.res_tag), 256'(exp_tag[0]));
          chk("res_last", 256'(bus.res_last), 256'(res_cnt == 15));
          res_cnt++;
          if (res_cnt == 16) begin
            void'(exp_tag.pop_front());
            res_cnt = 0;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.req_mode  = '0;
    bus.buf_ready = 1'b1;
    for (int i = 0; i < N; i++) target[i] = 0;
    step(2);

    do_reset();
    chk_reset_outputs("reset");

    // single requester, mode 1
    bus.req_mode[1:0] = 2'd1;
    plan(0, 1);
    target[0] += 16;
    wait_batches(1, 100);
    step(5);
    chk("single_handshakes", 256'(hs_total), 256'(16));
    chk("single_busy_pending", 256'(bus.busy), 256'(1));
    res_mode = 1;
    wait_idle(100);
    chk("single_results", 256'(res_total), 256'(16));

    // round robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < N; i++) bus.req_mode[i*2 +: 2] = 2'd3;
    plan(0, 3); plan(1, 3); plan(2, 3); plan(3, 3); plan(0, 3);
    target[0] += 32;
    for (int i = 1; i < N; i++) target[i] += 16;
    res_mode = 1;
    wait_batches(5, 600);
    wait_idle(200);
    chk("rr_handshakes", 256'(hs_total), 256'(80));
    chk("rr_results", 256'(res_total), 256'(80));

    // mode change: req0 mode 0, then req1 mode 2
    do_reset();
    bus.req_mode[1:0] = 2'd0;
    bus.req_mode[3:2] = 2'd2;
    plan(0, 0); plan(1, 2);
    target[0] += 16;
    target[1] += 16;
    wait_batches(1, 100);
    step(10);
    chk("mode_hold_no_grant", 256'(hs_total), 256'(16));
    chk("mode_hold_busy", 256'(bus.busy), 256'(1));
    res_mode = 1;
    wait_batches(2, 200);
    wait_idle(100);
    chk("mode_handshakes", 256'(hs_total), 256'(32));

    // tag FIFO full
    do_reset();
    for (int i = 0; i < N; i++) bus.req_mode[i*2 +: 2] = 2'd1;
    plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 1); plan(0, 1);
    target[0] += 32;
    for (int i = 1; i < N; i++) target[i] += 16;
    wait_batches(4, 200);
    step(20);
    chk("full_no_fifth", 256'(batches), 256'(4));
    chk("full_busy", 256'(bus.busy), 256'(1));
    res_mode = 1;
    wait_batches(5, 200);
    chk("grant_after_pop", 256'(batch_start_cyc - first_pop_cyc), 256'(2));
    wait_idle(200);

    // same-cycle push and pop
    do_reset();
    bus.req_mode[3:2] = 2'd0;
    bus.req_mode[5:4] = 2'd0;
    res_mode = 2;
    plan(1, 0);
    target[1] += 16;
    wait_batches(1, 100);
    bus.buf_ready = 1'b0;
    plan(2, 0);
    target[2] += 16;
    manual_vld = 1'b1;
    step(15);
    bus.buf_ready = 1'b1;
    step(1);
    manual_vld = 1'b0;
    wait_batches(2, 100);
    chk("push_pop_same", 256'(batch_start_cyc - first_pop_cyc), 256'(1));
    res_mode = 1;
    wait_idle(100);
    chk("push_pop_results", 256'(res_total), 256'(32));
    chk("push_pop_no_orphan", 256'(bus.err_orphan), 256'(0));

    // stall mid-batch, then reset
    do_reset();
    bus.req_mode[5:4] = 2'd3;
    plan(2, 3);
    target[2] += 7;
    wait_beats(7, 100);
    step(5);
    chk("stall_beat_cnt", 256'(dut.beat_cnt), 256'(7));
    chk("stall_busy", 256'(bus.busy), 256'(1));
    chk("stall_ready_held", 256'(bus.req_ready), 256'(4'b0100));
    chk("stall_buf_vld", 256'(bus.buf_vld), 256'(0));
    chk("stall_mode", 256'(bus.buf_mode), 256'(3));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset_outputs("stall_rst");

    // orphan result beat
    do_reset();
    res_mode = 2;
    manual_vld = 1'b1;
    step(1);
    manual_vld = 1'b0;
    step(1);
    chk("orphan_set", 256'(bus.err_orphan), 256'(1));
    step(5);
    chk("orphan_sticky", 256'(bus.err_orphan), 256'(1));
    chk("orphan_not_busy", 256'(bus.busy), 256'(0));
    do_reset();
    chk("orphan_cleared", 256'(bus.err_orphan), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
